// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_EXT = 1'b1;

  localparam int DEF_AW = 16;
  localparam int DEF_DW = 16;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way request picker: bit 0 is the CPU, bit 1 the external loader.
// gnt = 0 selects the CPU, gnt = 1 selects the loader. 'last' is the
// requester that won the previous tie-capable grant; 'prio' forces CPU on ties.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio,
  output logic       gnt
);

  // Single requests win outright; ties go to CPU or to whoever did not win last.
  always_comb begin
    gnt = 1'b0;
    case (req)
      2'b01:   gnt = 1'b0;
      2'b10:   gnt = 1'b1;
      2'b11:   gnt = prio ? 1'b0 : ~last;
      default: gnt = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single data-memory port between the microcoded CPU
// controller and the external loader/debug port. Each access runs for a fixed
// MEM_LAT cycles, then a one-cycle done pulse goes to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MEM_LAT  = 2,
  parameter int CPU_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_done,
  output logic          cpu_stall,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic [DW-1:0] ext_rdata,
  output logic          ext_done,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  if (MEM_LAT < 1) begin : g_lat_check
    $error("mem_arbiter: MEM_LAT must be at least 1");
  end

  localparam int          CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);
  localparam logic        PRIO_BIT = (CPU_PRIO != 0);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            lat_we;
  logic [AW-1:0]   lat_addr;
  logic [DW-1:0]   lat_wdata;
  logic            rr_pref;
  logic            pick;

  // rr_pref names the requester to favour on the next tie; the picker wants
  // the previous winner, which is the opposite of the favoured one.
  rr_arb2 u_pick (
    .req  ({ext_req, cpu_req}),
    .last (~rr_pref),
    .prio (PRIO_BIT),
    .gnt  (pick)
  );

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign busy      = (state != ST_IDLE);
  assign cpu_stall = cpu_req & ~cpu_done;

  // Access sequencer: grant and latch in IDLE, count latency in ACCESS,
  // pulse the owner's done in DONE; all memory-side outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      owner     <= OWN_CPU;
      rr_pref   <= OWN_CPU;
      cpu_rdata <= '0;
      ext_rdata <= '0;
      cpu_done  <= 1'b0;
      ext_done  <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      ext_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cpu_req || ext_req) begin
            owner     <= pick;
            lat_we    <= pick ? ext_we    : cpu_we;
            lat_addr  <= pick ? ext_addr  : cpu_addr;
            lat_wdata <= pick ? ext_wdata : cpu_wdata;
            mem_we    <= pick ? ext_we    : cpu_we;
            mem_en    <= 1'b1;
            cnt       <= CNT_INIT;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!lat_we) begin
              if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
              else                  ext_rdata <= mem_rdata;
            end
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            cpu_done <= (owner == OWN_CPU);
            ext_done <= (owner == OWN_EXT);
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          rr_pref <= ~owner;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LAT=2: a round-robin instance backed
// by a small RAM model, and a CPU-priority instance with a fixed read value.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        preload = 1'b0;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_done, cpu_stall;
  logic        ext_req = 1'b0, ext_we = 1'b0;
  logic [15:0] ext_addr = '0, ext_wdata = '0;
  logic [15:0] ext_rdata;
  logic        ext_done;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner;

  logic        p_cpu_req = 1'b0, p_ext_req = 1'b0;
  logic [15:0] p_cpu_rdata, p_ext_rdata;
  logic        p_cpu_done, p_cpu_stall, p_ext_done;
  logic        p_mem_en, p_mem_we;
  logic [15:0] p_mem_addr, p_mem_wdata;
  logic [15:0] p_mem_rdata;
  logic        p_busy, p_owner;

  logic [15:0] ram [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Memory model: preload one word during reset, otherwise store writes.
  always @(posedge clk) begin
    if (preload) ram[8'h12] <= 16'hBEEF;
    else if (mem_en && mem_we) ram[mem_addr[7:0]] <= mem_wdata;
  end

  assign mem_rdata   = mem_en ? ram[mem_addr[7:0]] : 16'h0000;
  assign p_mem_rdata = 16'hA5A5;

  mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(2), .CPU_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(2), .CPU_PRIO(1)) dut_p (
    .clk(clk), .rst(rst),
    .cpu_req(p_cpu_req), .cpu_we(1'b0), .cpu_addr(16'h0001), .cpu_wdata(16'h0000),
    .cpu_rdata(p_cpu_rdata), .cpu_done(p_cpu_done), .cpu_stall(p_cpu_stall),
    .ext_req(p_ext_req), .ext_we(1'b0), .ext_addr(16'h0002), .ext_wdata(16'h0000),
    .ext_rdata(p_ext_rdata), .ext_done(p_ext_done),
    .mem_en(p_mem_en), .mem_we(p_mem_we), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_rdata(p_mem_rdata), .busy(p_busy), .owner(p_owner)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    preload = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({mem_en, mem_we} !== 2'b00) begin errors++; $display("[TB] FAIL reset_mem: got %b expected 00", {mem_en, mem_we}); end
    checks++; if ({cpu_done, ext_done, owner, cpu_stall} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 0000", {cpu_done, ext_done, owner, cpu_stall}); end
    checks++; if ({cpu_rdata, ext_rdata} !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", {cpu_rdata, ext_rdata}); end
    preload = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_we = 1'b0; cpu_addr = 16'h0012; cpu_req = 1'b1;
    #1;
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL rd_stall_req: got %b expected 1", cpu_stall); end
    tick();
    checks++; if ({mem_en, mem_we, busy, owner} !== 4'b1010) begin errors++; $display("[TB] FAIL rd_acc1: got %b expected 1010", {mem_en, mem_we, busy, owner}); end
    checks++; if (mem_addr !== 16'h0012) begin errors++; $display("[TB] FAIL rd_addr: got %h expected 0012", mem_addr); end
    tick();
    checks++; if ({mem_en, cpu_done, cpu_stall} !== 3'b101) begin errors++; $display("[TB] FAIL rd_acc2: got %b expected 101", {mem_en, cpu_done, cpu_stall}); end
    tick();
    checks++; if ({mem_en, cpu_done, cpu_stall, ext_done} !== 4'b0100) begin errors++; $display("[TB] FAIL rd_done: got %b expected 0100", {mem_en, cpu_done, cpu_stall, ext_done}); end
    checks++; if (cpu_rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd_data: got %h expected beef", cpu_rdata); end
    cpu_req = 1'b0;
    tick();
    checks++; if ({cpu_done, busy} !== 2'b00) begin errors++; $display("[TB] FAIL rd_idle: got %b expected 00", {cpu_done, busy}); end
    tick();
    checks++; if ({mem_en, busy, cpu_rdata} !== {2'b00, 16'hBEEF}) begin errors++; $display("[TB] FAIL rd_hold: got %h expected 0beef", {mem_en, busy, cpu_rdata}); end
  endtask

  task automatic test_ext_write();
    ext_we = 1'b1; ext_addr = 16'h0040; ext_wdata = 16'h1234; ext_req = 1'b1;
    tick();
    ext_addr = 16'hFFFF; ext_wdata = 16'h0BAD;
    checks++; if ({mem_en, mem_we, owner} !== 3'b111) begin errors++; $display("[TB] FAIL wr_acc1: got %b expected 111", {mem_en, mem_we, owner}); end
    checks++; if ({mem_addr, mem_wdata} !== {16'h0040, 16'h1234}) begin errors++; $display("[TB] FAIL wr_bus: got %h expected 00401234", {mem_addr, mem_wdata}); end
    tick();
    checks++; if ({mem_we, ext_done} !== 2'b10) begin errors++; $display("[TB] FAIL wr_acc2: got %b expected 10", {mem_we, ext_done}); end
    tick();
    checks++; if ({ext_done, cpu_done, mem_en} !== 3'b100) begin errors++; $display("[TB] FAIL wr_done: got %b expected 100", {ext_done, cpu_done, mem_en}); end
    checks++; if ({ext_rdata, cpu_rdata} !== {16'h0000, 16'hBEEF}) begin errors++; $display("[TB] FAIL wr_rdata: got %h expected 0000beef", {ext_rdata, cpu_rdata}); end
    ext_req = 1'b0; ext_we = 1'b0;
    tick();
    checks++; if ({ext_done, busy} !== 2'b00) begin errors++; $display("[TB] FAIL wr_pulse: got %b expected 00", {ext_done, busy}); end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_rd;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cpu_we = 1'b0; cpu_addr = 16'h0040;
    ext_we = 1'b0; ext_addr = 16'h0012;
    cpu_req = 1'b1; ext_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      exp_rd = (g % 2 == 0) ? 16'h1234 : 16'hBEEF;
      tick();
      checks++; if ({owner, busy} !== {(g % 2 == 1), 1'b1}) begin errors++; $display("[TB] FAIL rr_owner%0d: got %b expected %b1", g, owner, (g % 2 == 1)); end
      tick();
      tick();
      checks++; if ({cpu_done, ext_done} !== ((g % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL rr_done%0d: got %b", g, {cpu_done, ext_done}); end
      checks++; if (((g % 2 == 0) ? cpu_rdata : ext_rdata) !== exp_rd) begin errors++; $display("[TB] FAIL rr_data%0d: got %h expected %h", g, (g % 2 == 0) ? cpu_rdata : ext_rdata, exp_rd); end
      tick();
      checks++; if ({busy, cpu_done, ext_done} !== 3'b000) begin errors++; $display("[TB] FAIL rr_gap%0d: got %b expected 000", g, {busy, cpu_done, ext_done}); end
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    tick();
  endtask

  task automatic test_cpu_prio();
    p_cpu_req = 1'b1; p_ext_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      tick();
      checks++; if ({p_owner, p_mem_en} !== 2'b01) begin errors++; $display("[TB] FAIL prio_owner%0d: got %b expected 01", g, {p_owner, p_mem_en}); end
      tick();
      tick();
      checks++; if ({p_cpu_done, p_ext_done, p_cpu_rdata} !== {2'b10, 16'hA5A5}) begin errors++; $display("[TB] FAIL prio_done%0d: got %h", g, {p_cpu_done, p_ext_done, p_cpu_rdata}); end
      tick();
    end
    p_cpu_req = 1'b0;
    tick();
    checks++; if (p_owner !== 1'b1) begin errors++; $display("[TB] FAIL prio_ext_owner: got %b expected 1", p_owner); end
    tick();
    tick();
    checks++; if ({p_ext_done, p_ext_rdata} !== {1'b1, 16'hA5A5}) begin errors++; $display("[TB] FAIL prio_ext_done: got %h", {p_ext_done, p_ext_rdata}); end
    p_ext_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    cpu_we = 1'b0; cpu_addr = 16'h0012; cpu_req = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if ({mem_en, mem_we, busy, cpu_done} !== 4'b0000) begin errors++; $display("[TB] FAIL abort_now: got %b expected 0000", {mem_en, mem_we, busy, cpu_done}); end
    tick();
    checks++; if ({cpu_done, cpu_rdata} !== 17'h0) begin errors++; $display("[TB] FAIL abort_nodone: got %h expected 0", {cpu_done, cpu_rdata}); end
    rst = 1'b1;
    tick();
    checks++; if ({busy, mem_en, owner} !== 3'b110) begin errors++; $display("[TB] FAIL abort_regrant: got %b expected 110", {busy, mem_en, owner}); end
    tick();
    tick();
    checks++; if ({cpu_done, cpu_rdata} !== {1'b1, 16'hBEEF}) begin errors++; $display("[TB] FAIL abort_redone: got %h", {cpu_done, cpu_rdata}); end
    cpu_req = 1'b0;
    tick();
  endtask

  task automatic test_stall_behind_ext();
    ext_we = 1'b1; ext_addr = 16'h0050; ext_wdata = 16'h7777; ext_req = 1'b1;
    tick();
    cpu_we = 1'b0; cpu_addr = 16'h0050; cpu_req = 1'b1;
    #1;
    checks++; if ({owner, cpu_stall} !== 2'b11) begin errors++; $display("[TB] FAIL st_ext_acc: got %b expected 11", {owner, cpu_stall}); end
    tick();
    tick();
    checks++; if ({ext_done, cpu_stall} !== 2'b11) begin errors++; $display("[TB] FAIL st_ext_done: got %b expected 11", {ext_done, cpu_stall}); end
    ext_req = 1'b0; ext_we = 1'b0;
    tick();
    checks++; if ({busy, cpu_stall} !== 2'b01) begin errors++; $display("[TB] FAIL st_idle: got %b expected 01", {busy, cpu_stall}); end
    tick();
    checks++; if ({owner, cpu_stall, mem_en} !== 3'b011) begin errors++; $display("[TB] FAIL st_cpu_grant: got %b expected 011", {owner, cpu_stall, mem_en}); end
    tick();
    checks++; if (cpu_stall !== 1'b1) begin errors++; $display("[TB] FAIL st_cpu_acc2: got %b expected 1", cpu_stall); end
    tick();
    checks++; if ({cpu_done, cpu_stall, cpu_rdata} !== {2'b10, 16'h7777}) begin errors++; $display("[TB] FAIL st_cpu_done: got %h", {cpu_done, cpu_stall, cpu_rdata}); end
    cpu_req = 1'b0;
    tick();
    checks++; if ({cpu_stall, busy} !== 2'b00) begin errors++; $display("[TB] FAIL st_end: got %b expected 00", {cpu_stall, busy}); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ext_write();
    test_round_robin();
    test_cpu_prio();
    test_reset_abort();
    test_stall_behind_ext();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
